// File: rtl/even_divisor_monitor_if.sv
// Handshake/status bundle between an even-divider monitor and its controller.
interface even_divisor_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] ratio;
  logic             div_in;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic             period_vld;
  logic             locked;
  logic             err;

  modport master (
    output en, ratio, div_in, err_clr,
    input  period, high, period_vld, locked, err
  );

  modport slave (
    input  en, ratio, div_in, err_clr,
    output period, high, period_vld, locked, err
  );
endinterface

// File: rtl/even_divisor_monitor.sv
// Samples a divided clock as data on clk, measures its period and high time,
// and checks both against a programmed even ratio (lock + sticky error).
module even_divisor_monitor #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned LOCK_N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  even_divisor_monitor_if.slave bus
);

  localparam int unsigned GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_TRACK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t           state;
  logic             div_q;
  logic [CNT_W-1:0] p_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] h_meas;
  logic [CNT_W-1:0] ratio_q;
  logic [GW-1:0]    good_cnt;
  logic             cfg_err;

  logic rise;
  logic fall;
  logic active;
  logic measuring;
  logic timeout;
  logic cmp_vld;
  logic cmp_good;
  logic cmp_bad;
  logic cfg_bad;
  logic err_set;

  // Edge detect, timeout, compare and error-source decode.
  always_comb begin
    rise      = 1'b0;
    fall      = 1'b0;
    active    = 1'b0;
    measuring = 1'b0;
    timeout   = 1'b0;
    cmp_vld   = 1'b0;
    cmp_good  = 1'b0;
    cmp_bad   = 1'b0;
    cfg_bad   = 1'b0;
    err_set   = 1'b0;

    rise      = bus.div_in & ~div_q;
    fall      = ~bus.div_in & div_q;
    active    = (state != S_IDLE);
    measuring = (state == S_TRACK) || (state == S_LOCKED);
    // Widened compare so 2*ratio never wraps; saturation also counts as a stall.
    timeout   = active && !rise &&
                (({1'b0, p_cnt} == {ratio_q, 1'b0}) || (p_cnt == '1));
    cmp_vld   = measuring && bus.period_vld;
    cmp_good  = cmp_vld && (bus.period == ratio_q) && (bus.high == (ratio_q >> 1));
    cmp_bad   = cmp_vld && !cmp_good;
    cfg_bad   = bus.ratio[0] || (bus.ratio < CNT_W'(2));
    err_set   = bus.en && (((state == S_IDLE) && !cfg_err && cfg_bad) || timeout || cmp_bad);
  end

  // Period and high-time counters plus the div_in history bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= 1'b0;
      p_cnt  <= '0;
      h_cnt  <= '0;
      h_meas <= '0;
    end else begin
      div_q <= bus.div_in;
      if (!active) begin
        p_cnt <= '0;
        h_cnt <= '0;
      end else begin
        if (rise)
          p_cnt <= CNT_W'(1);
        else if (p_cnt != '1)
          p_cnt <= p_cnt + CNT_W'(1);

        if (rise)
          h_cnt <= CNT_W'(1);
        else if (bus.div_in && (h_cnt != '1))
          h_cnt <= h_cnt + CNT_W'(1);
      end
      if (fall)
        h_meas <= h_cnt;
    end
  end

  // Monitor state machine with registered measurement and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      ratio_q        <= '0;
      good_cnt       <= '0;
      cfg_err        <= 1'b0;
      bus.period     <= '0;
      bus.high       <= '0;
      bus.period_vld <= 1'b0;
      bus.locked     <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.period_vld <= 1'b0;
      if (bus.en && rise && measuring) begin
        bus.period     <= p_cnt;
        bus.high       <= h_meas;
        bus.period_vld <= 1'b1;
      end

      // A new error in the same cycle as a clear keeps err set.
      if (err_set)
        bus.err <= 1'b1;
      else if (bus.err_clr)
        bus.err <= 1'b0;

      if (!bus.en) begin
        state      <= S_IDLE;
        bus.locked <= 1'b0;
        good_cnt   <= '0;
        cfg_err    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!cfg_err) begin
              ratio_q <= bus.ratio;
              if (cfg_bad)
                cfg_err <= 1'b1;
              else
                state <= S_ACQ;
            end
          end
          S_ACQ: begin
            if (!timeout && rise) begin
              state    <= S_TRACK;
              good_cnt <= '0;
            end
          end
          S_TRACK: begin
            if (timeout) begin
              state      <= S_ACQ;
              bus.locked <= 1'b0;
              good_cnt   <= '0;
            end else if (cmp_good) begin
              good_cnt <= good_cnt + GW'(1);
              if (good_cnt == GW'(LOCK_N - 1)) begin
                state      <= S_LOCKED;
                bus.locked <= 1'b1;
              end
            end else if (cmp_bad) begin
              good_cnt <= '0;
            end
          end
          S_LOCKED: begin
            if (timeout) begin
              state      <= S_ACQ;
              bus.locked <= 1'b0;
              good_cnt   <= '0;
            end else if (cmp_bad) begin
              state      <= S_TRACK;
              bus.locked <= 1'b0;
              good_cnt   <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
